seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. A single shared hex-to-7-segment decode path is sequenced across NUM_DIGITS digits, one digit at a time. For each digit the block drives the digit-enable, segment and decimal-point lines, with a blanking gap between digits to prevent ghosting. It sits between the value-producing logic (counters, registers) and the board display pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scan_ctrl_if.sv | 28 ++
 rtl/seg7_decode_lut.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// seg7_pkg : shared FSM states and hex-to-segment table.      Rev 1.0
// ------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low a..g, index = hex nibble value
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// seg7_scan_ctrl_if : value-side inputs and display-pin outputs. Rev 1.0
// ------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic [6:0]                seg7;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_done;

  modport master (
    output en, load, value, dp_in, blank_lz,
    input  seg7, dp_n, an_n, frame_done
  );

  modport slave (
    input  en, load, value, dp_in, blank_lz,
    output seg7, dp_n, an_n, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_decode_lut.sv
`default_nettype none
// ------------------------------------------------------------------------
// seg7_decode_lut : combinational nibble to active-low segments. Rev 1.0
// ------------------------------------------------------------------------
module seg7_decode_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nibble];
endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// seg7_scan_ctrl : multiplexed 7-segment scan FSM with frame-atomic shadow.
// Rev 1.0
// ------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  logic                    commit;

  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic [4*NUM_DIGITS-1:0] shadow_val, pend_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
  logic                    pend_valid;

  logic [3:0]              nibble;
  logic [6:0]              lut_seg;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [6:0]              digit_seg;
  logic                    digit_dpn;

  // Single shared decoder, fed from the digit currently being prepared
  assign nibble = shadow_val[{idx, 2'b00} +: 4];

  seg7_decode_lut u_lut (
    .nibble (nibble),
    .seg    (lut_seg)
  );

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the shadow are all zero
  always_comb begin
    logic z;
    z          = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z             = z & (shadow_val[4*i +: 4] == 4'h0);
      upper_zero[i] = z;
    end
  end

  assign digit_seg = (bus.blank_lz && (idx != '0) && upper_zero[idx]) ? SEG_OFF : lut_seg;
  assign digit_dpn = ~shadow_dp[idx];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    commit  = 1'b0;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dpn_d   = 1'b1;
    fd_d    = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          commit  = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx == IDX_LAST) begin
              idx_d  = '0;
              commit = 1'b1;
            end else begin
              idx_d = idx + 1'b1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so they are derived from the next state;
    // frame_done therefore lands on the final DRIVE cycle of the last digit.
    if (state_d == DRIVE) begin
      an_d = ~(NUM_DIGITS'(1) << idx_d);
      if (state == DRIVE) begin
        seg_d = seg_q;
        dpn_d = dpn_q;
      end else begin
        seg_d = digit_seg;
        dpn_d = digit_dpn;
      end
      fd_d = (cnt_d == DRIVE_LAST) && (idx_d == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      seg_q <= SEG_OFF;
      dpn_q <= 1'b1;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      an_q  <= an_d;
      fd_q  <= fd_d;
    end
  end

  // A load landing on a commit cycle bypasses the pending register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (commit) begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end else if (pend_valid) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_val   <= bus.value;
      pend_dp    <= bus.dp_in;
      pend_valid <= 1'b1;
    end
  end

  assign bus.seg7       = seg_q;
  assign bus.dp_n       = dpn_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_seg7_scan_ctrl : directed scan sequences checked by a digit scoreboard.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S4  = 7'b1001100;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] SC  = 7'b0110001;
  localparam logic [6:0] SD  = 7'b1000010;
  localparam logic [6:0] SE  = 7'b0110000;
  localparam logic [6:0] SF  = 7'b0111000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks  = 0;
  int          errors  = 0;
  logic [11:0] exp_q [$];
  bit          mon_on  = 1'b0;
  bit          chk_len = 1'b0;
  bit          tail_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected {an_n, seg7, dp_n} for the first n digits of one frame
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpn, input int n);
    logic [6:0] s [4];
    logic [3:0] an;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < n; i++) begin
      an    = 4'hF;
      an[i] = 1'b0;
      exp_q.push_back({an, s[i], dpn[i]});
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.an_n !== tgt && n < 200);
    if (bus.an_n !== tgt) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s an_n=%b expected=%b", name, bus.an_n, tgt);
    end
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 200);
    if (bus.frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s frame_done=%b expected=1", name, bus.frame_done);
    end
  endtask

  task automatic check_dark(input string name);
    check(name, {bus.an_n, bus.seg7, bus.dp_n, bus.frame_done}, {4'hF, OFF, 1'b1, 1'b0});
  endtask

  // Monitor: one scoreboard pop per digit drive, plus timing checks
  initial begin : monitor
    logic [3:0]  prev_an;
    logic [11:0] e;
    int          run_len;
    int          dark_len;
    prev_an  = 4'hF;
    run_len  = 0;
    dark_len = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus.an_n != 4'hF) begin
          if (prev_an == 4'hF) begin
            if (chk_len) check("blank_len", dark_len, BC);
            if (exp_q.size() == 0) begin
              if (!tail_ok) begin
                checks++;
                errors++;
                $display("FAIL unexpected_drive actual=%b expected=none", bus.an_n);
              end
            end else begin
              e = exp_q.pop_front();
              check("digit", {bus.an_n, bus.seg7, bus.dp_n}, e);
            end
            run_len = 1;
          end else begin
            run_len++;
          end
        end else begin
          if (prev_an != 4'hF && chk_len) check("drive_len", run_len, RD);
          dark_len = (prev_an == 4'hF) ? dark_len + 1 : 1;
        end
        if (bus.frame_done)
          check("frame_done_pos", {bus.an_n, run_len[3:0]}, {4'b0111, 4'd4});
        prev_an = bus.an_n;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin : stimulus
    bus.en       = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;

    // Reset held for two edges with en high
    repeat (2) @(negedge clk);
    check("rst_seg7", bus.seg7, OFF);
    check("rst_an_n", bus.an_n, 4'hF);
    check("rst_dp_n", bus.dp_n, 1'b1);
    check("rst_frame_done", bus.frame_done, 1'b0);

    // Load coincides with the IDLE->BLANK commit, so FEDC shows in frame 1
    push_frame(SC, SD, SE, SF, 4'hF, 4);
    push_frame(SC, SD, SE, SF, 4'hF, 4);
    rst_n     = 1'b1;
    bus.load  = 1'b1;
    bus.value = 16'hFEDC;
    bus.dp_in = 4'h0;
    mon_on    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("post_reset_blank", bus.an_n, 4'hF);
    wait_an(4'b1110, "first_drive");
    @(posedge clk);
    chk_len = 1'b1;

    // Mid-frame load must not tear frame 2
    wait_fd("frame1");
    wait_an(4'b1101, "f2_d1");
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    push_frame(S4, S3, S2, S1, 4'hF, 4);
    @(negedge clk);
    bus.load = 1'b0;

    // Leading-zero blanking with a dp on a blanked digit
    wait_fd("frame2");
    wait_an(4'b1110, "f3_d0");
    bus.blank_lz = 1'b1;
    bus.load     = 1'b1;
    bus.value    = 16'h0005;
    bus.dp_in    = 4'b0010;
    push_frame(S5, OFF, OFF, OFF, 4'b1101, 4);
    @(negedge clk);
    bus.load = 1'b0;

    wait_fd("frame3");
    wait_an(4'b1110, "f4_d0");
    bus.load  = 1'b1;
    bus.value = 16'h0000;
    bus.dp_in = 4'b0000;
    push_frame(S0, OFF, OFF, OFF, 4'hF, 3);
    @(negedge clk);
    bus.load = 1'b0;

    // Drop en during digit 2 drive
    wait_fd("frame4");
    wait_an(4'b1011, "f5_d2");
    chk_len = 1'b0;
    bus.en  = 1'b0;
    @(negedge clk);
    check_dark("en_off_1");
    @(negedge clk);
    check_dark("en_off_2");
    push_frame(S0, OFF, OFF, OFF, 4'hF, 3);
    bus.en = 1'b1;
    @(negedge clk);
    check("restart_blank", bus.an_n, 4'hF);
    @(negedge clk);
    check("restart_drive", {bus.an_n, bus.seg7}, {4'b1110, S0});
    @(posedge clk);
    chk_len = 1'b1;

    // Pending FEDC must be discarded by a mid-frame reset
    wait_an(4'b1101, "f6_d1");
    bus.load  = 1'b1;
    bus.value = 16'hFEDC;
    @(negedge clk);
    bus.load = 1'b0;
    wait_an(4'b1011, "f6_d2");
    chk_len      = 1'b0;
    rst_n        = 1'b0;
    bus.blank_lz = 1'b0;
    push_frame(S0, S0, S0, S0, 4'hF, 4);
    push_frame(S0, S0, S0, S0, 4'hF, 4);
    @(negedge clk);
    @(negedge clk);
    check_dark("mid_reset_dark");
    rst_n = 1'b1;
    wait_an(4'b1110, "f7_d0");
    @(posedge clk);
    chk_len = 1'b1;
    wait_fd("frame7");
    wait_fd("frame8");
    tail_ok = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
